// File: rtl/sfixed_dot_accum.sv
// -----------------------------------------------------------------------------
// sfixed_dot_accum
//
// Accumulates a stream of signed fixed-point product pairs (the x and y lanes of
// a dual multiplier) into a saturating accumulator. When the beat flagged
// in_last is accepted, the sum is rescaled to the output format, clamped, and
// held on the output port until the consumer takes it.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   product pair present on in_x / in_y
//   in_ready   block accepts a beat this cycle (low while a result is held)
//   in_x       signed product term, Q(IN_LEFT).(IN_RIGHT)
//   in_y       signed product term, Q(IN_LEFT).(IN_RIGHT)
//   in_last    final beat of the current dot product
//   out_valid  result held on out_data / out_count / out_sat
//   out_ready  consumer takes the result
//   out_data   signed saturated result, Q(OUT_LEFT).(OUT_RIGHT)
//   out_count  beats accepted for this result (saturates at all-ones)
//   out_sat    accumulator or output clamping occurred for this result
// -----------------------------------------------------------------------------
module sfixed_dot_accum #(
    parameter int IN_LEFT   = 7,
    parameter int IN_RIGHT  = 8,
    parameter int OUT_LEFT  = 7,
    parameter int OUT_RIGHT = 8,
    parameter int ACC_GUARD = 4,
    parameter int CNT_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IN_LEFT+IN_RIGHT:0]     in_x,
    input  logic [IN_LEFT+IN_RIGHT:0]     in_y,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_LEFT+OUT_RIGHT:0]   out_data,
    output logic [CNT_W-1:0]              out_count,
    output logic                          out_sat
);

    localparam int IN_W  = IN_LEFT + IN_RIGHT + 1;
    localparam int ACC_W = IN_W + ACC_GUARD + 1;
    // Two extra bits hold acc + x + y without wrapping before the clamp.
    localparam int SUM_W = ACC_W + 2;
    localparam int OUT_W = OUT_LEFT + OUT_RIGHT + 1;
    localparam int SHIFT = IN_RIGHT - OUT_RIGHT;
    // Comparison width covering both the shifted accumulator and the output range.
    localparam int CMP_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] ACC_MAX_X = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN_X = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [CMP_W-1:0] OUT_MAX_X = {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CMP_W-1:0] OUT_MIN_X = {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_HOLD
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;

    logic signed [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_sticky;
    logic [OUT_W-1:0]         r_out_data;
    logic [CNT_W-1:0]         r_out_count;
    logic                     r_out_sat;

    logic                     w_accept;
    logic                     w_release;
    logic signed [ACC_W-1:0]  w_acc_base;
    logic signed [SUM_W-1:0]  w_base_ext;
    logic signed [SUM_W-1:0]  w_x_ext;
    logic signed [SUM_W-1:0]  w_y_ext;
    logic signed [SUM_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic                     w_acc_clamp;
    logic signed [ACC_W-1:0]  w_acc_shifted;
    logic signed [CMP_W-1:0]  w_shift_ext;
    logic [OUT_W-1:0]         w_out_next;
    logic                     w_out_clamp;
    logic [CNT_W-1:0]         w_cnt_next;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    // NOTE: state and datapath registers use non-blocking assignments so every
    // always_ff block samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = in_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_accept  = in_valid && in_ready;
    assign w_release = out_valid && out_ready;

    // ------------------------------------------------------------------------
    // Saturating accumulate
    // ------------------------------------------------------------------------
    // A fresh dot product always starts from zero, whatever r_acc holds.
    assign w_acc_base = (r_state == ST_IDLE) ? '0 : r_acc;
    assign w_base_ext = {{(SUM_W-ACC_W){w_acc_base[ACC_W-1]}}, w_acc_base};
    assign w_x_ext    = {{(SUM_W-IN_W){in_x[IN_W-1]}}, in_x};
    assign w_y_ext    = {{(SUM_W-IN_W){in_y[IN_W-1]}}, in_y};
    assign w_sum      = w_base_ext + w_x_ext + w_y_ext;

    always_comb begin
        w_acc_next  = w_sum[ACC_W-1:0];
        w_acc_clamp = 1'b0;
        if (w_sum > ACC_MAX_X) begin
            w_acc_next  = ACC_MAX;
            w_acc_clamp = 1'b1;
        end else if (w_sum < ACC_MIN_X) begin
            w_acc_next  = ACC_MIN;
            w_acc_clamp = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Output rescale: arithmetic shift drops fraction bits (floor), then clamp
    // ------------------------------------------------------------------------
    assign w_acc_shifted = w_acc_next >>> SHIFT;
    assign w_shift_ext   = {{(CMP_W-ACC_W){w_acc_shifted[ACC_W-1]}}, w_acc_shifted};

    always_comb begin
        w_out_next  = w_shift_ext[OUT_W-1:0];
        w_out_clamp = 1'b0;
        if (w_shift_ext > OUT_MAX_X) begin
            w_out_next  = OUT_MAX;
            w_out_clamp = 1'b1;
        end else if (w_shift_ext < OUT_MIN_X) begin
            w_out_next  = OUT_MIN;
            w_out_clamp = 1'b1;
        end
    end

    // Beat counter sticks at all-ones; that is not reported as saturation.
    assign w_cnt_next = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sticky    <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_accept) begin
            r_acc    <= w_acc_next;
            r_cnt    <= w_cnt_next;
            r_sticky <= r_sticky | w_acc_clamp;
            if (in_last) begin
                // Result is captured on the same edge that accepts the last beat.
                r_out_data  <= w_out_next;
                r_out_count <= w_cnt_next;
                r_out_sat   <= r_sticky | w_acc_clamp | w_out_clamp;
            end
        end else if (w_release) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sticky    <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_sfixed_dot_accum.sv
// -----------------------------------------------------------------------------
// tb_sfixed_dot_accum
//
// Self-checking bench for sfixed_dot_accum with default parameters (Q7.8 in and
// out). Directed cases cover reset, single-beat, multi-beat, saturation,
// back-pressure and mid-transaction reset; randomized transactions follow.
// Expected results come from an integer model of the dot product.
// -----------------------------------------------------------------------------
module tb_sfixed_dot_accum;

    localparam int IN_LEFT   = 7;
    localparam int IN_RIGHT  = 8;
    localparam int OUT_LEFT  = 7;
    localparam int OUT_RIGHT = 8;
    localparam int ACC_GUARD = 4;
    localparam int CNT_W     = 8;

    localparam int IN_W  = IN_LEFT + IN_RIGHT + 1;
    localparam int OUT_W = OUT_LEFT + OUT_RIGHT + 1;
    localparam int ACC_W = IN_W + ACC_GUARD + 1;

    localparam longint ACC_HI  = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint ACC_LO  = -(longint'(1) <<< (ACC_W - 1));
    localparam longint OUT_HI  = (longint'(1) <<< (OUT_W - 1)) - 1;
    localparam longint OUT_LO  = -(longint'(1) <<< (OUT_W - 1));
    localparam longint CNT_MAX = (longint'(1) <<< CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_x;
    logic [IN_W-1:0]  in_y;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    int n_vectors = 0;
    int n_miscompares = 0;

    logic [IN_W-1:0] q_x[$];
    logic [IN_W-1:0] q_y[$];

    sfixed_dot_accum #(
        .IN_LEFT   (IN_LEFT),
        .IN_RIGHT  (IN_RIGHT),
        .OUT_LEFT  (OUT_LEFT),
        .OUT_RIGHT (OUT_RIGHT),
        .ACC_GUARD (ACC_GUARD),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: sum every term with plain integers, clamping the running sum
    // to the accumulator range, then floor-divide to the output scale and clamp.
    task automatic model(output logic [OUT_W-1:0] d, output logic [CNT_W-1:0] c, output logic s);
        longint acc;
        longint res;
        acc = 0;
        s   = 1'b0;
        foreach (q_x[i]) begin
            acc = acc + longint'($signed(q_x[i])) + longint'($signed(q_y[i]));
            if (acc > ACC_HI) begin
                acc = ACC_HI;
                s = 1'b1;
            end else if (acc < ACC_LO) begin
                acc = ACC_LO;
                s = 1'b1;
            end
        end
        res = acc >>> (IN_RIGHT - OUT_RIGHT);
        if (res > OUT_HI) begin
            res = OUT_HI;
            s = 1'b1;
        end else if (res < OUT_LO) begin
            res = OUT_LO;
            s = 1'b1;
        end
        d = res[OUT_W-1:0];
        c = (q_x.size() > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : CNT_W'(q_x.size());
    endtask

    // Drives the beats in q_x/q_y (optional idle gaps), checks the result one
    // cycle after the last beat, optionally holds back-pressure for bp_cycles
    // while offering junk beats, then completes the handshake.
    task automatic run_txn(input string tag, input int gap_max, input int bp_cycles);
        logic [OUT_W-1:0] exp_d;
        logic [CNT_W-1:0] exp_c;
        logic             exp_s;
        int               w;
        model(exp_d, exp_c, exp_s);
        out_ready = (bp_cycles == 0);
        foreach (q_x[i]) begin
            if (gap_max > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_x     = q_x[i];
            in_y     = q_y[i];
            in_last  = (i == q_x.size() - 1);
            w = 0;
            while (!in_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready) check({tag, "_beat_ready"}, {31'd0, in_ready}, 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"},  {16'd0, out_data},  {16'd0, exp_d});
        check({tag, "_count"}, {24'd0, out_count}, {24'd0, exp_c});
        check({tag, "_sat"},   {31'd0, out_sat},   {31'd0, exp_s});
        for (int k = 0; k < bp_cycles; k++) begin
            in_valid = 1'b1;
            in_x     = IN_W'($urandom);
            in_y     = IN_W'($urandom);
            in_last  = $urandom_range(1, 0);
            @(negedge clk);
            check({tag, "_bp_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_bp_data"},  {16'd0, out_data},  {16'd0, exp_d});
            check({tag, "_bp_count"}, {24'd0, out_count}, {24'd0, exp_c});
            check({tag, "_bp_sat"},   {31'd0, out_sat},   {31'd0, exp_s});
            check({tag, "_bp_ready"}, {31'd0, in_ready},  32'd0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_done_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_done_ready"}, {31'd0, in_ready},  32'd1);
    endtask

    task automatic load(input int n, input logic [IN_W-1:0] x, input logic [IN_W-1:0] y);
        q_x.delete();
        q_y.delete();
        for (int i = 0; i < n; i++) begin
            q_x.push_back(x);
            q_y.push_back(y);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #3;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data",  {16'd0, out_data},  32'd0);
        check("rst_count", {24'd0, out_count}, 32'd0);
        check("rst_sat",   {31'd0, out_sat},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Single beat 1.5 + 0.5 = 2.0
        load(1, 16'h0180, 16'h0080);
        run_txn("one_beat", 0, 0);

        // Three beats of 1+1, then four beats of 1-1
        load(3, 16'h0100, 16'h0100);
        run_txn("three_beat", 0, 0);
        load(4, 16'h0100, 16'hFF00);
        run_txn("cancel", 0, 0);

        // Output clamping at both ends
        load(2, 16'h7FFF, 16'h7FFF);
        run_txn("pos_clamp", 0, 0);
        load(2, 16'h8000, 16'h8000);
        run_txn("neg_clamp", 0, 0);

        // Accumulator clamp, then pulled back into range: sticky flag must survive
        load(20, 16'h7FFF, 16'h7FFF);
        for (int i = 0; i < 16; i++) begin
            q_x.push_back(16'h8000);
            q_y.push_back(16'h8000);
        end
        run_txn("acc_sticky", 0, 0);

        // Beat counter saturation without out_sat
        q_x.delete();
        q_y.delete();
        for (int i = 0; i < 300; i++) begin
            q_x.push_back(IN_W'($urandom_range(15, 0)));
            q_y.push_back(IN_W'(-$urandom_range(15, 0)));
        end
        run_txn("cnt_sat", 0, 0);

        // Back-pressure for five cycles with junk beats offered
        load(2, 16'h0040, 16'h0123);
        run_txn("backpressure", 0, 5);

        // Reset after two of three beats discards the partial sum
        in_valid = 1'b1;
        in_x     = 16'h0100;
        in_y     = 16'h0100;
        in_last  = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_count", {24'd0, out_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        load(1, 16'h0100, 16'h0100);
        run_txn("after_rst", 0, 0);

        // Reset while a result is held clears the outputs asynchronously
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_x      = 16'h0300;
        in_y      = 16'h0100;
        in_last   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("hold_pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("hold_rst_valid", {31'd0, out_valid}, 32'd0);
        check("hold_rst_data",  {16'd0, out_data},  32'd0);
        check("hold_rst_ready", {31'd0, in_ready},  32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            int n;
            n = $urandom_range(8, 1);
            q_x.delete();
            q_y.delete();
            for (int i = 0; i < n; i++) begin
                q_x.push_back(IN_W'($urandom));
                q_y.push_back(IN_W'($urandom));
            end
            run_txn($sformatf("rand%0d", t), 2, $urandom_range(3, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
